debounce_sync: RTL and testbench

//   Conditions a raw asynchronous input (push-button / switch) into a clean,
//   clk-synchronous level for the D flip-flop stage downstream (drives its d).

---
 rtl/debounce_sync.sv | 117 +++++++++++
 tb/tb_debounce_sync.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Raw asynchronous input -> synchroniser chain -> stability-counter debouncer.
// Emits a clean level plus single-cycle rise/fall pulses, all registered.
module debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic d_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] s;
   logic                   s_sync;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             d_nxt, rise_nxt, fall_nxt, busy_nxt;

   // Plain shift chain: nothing may sit between synchroniser flops.
   always_ff @(posedge clk) begin
      if (rst) s <= '0;
      else     s <= {s[SYNC_STAGES-2:0], btn_in};
   end

   assign s_sync = s[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE_LO;
         cnt        <= '0;
         d_out      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         d_out      <= d_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
         busy       <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      d_nxt     = d_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LO: begin
            d_nxt = 1'b0;
            if (s_sync) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!s_sync) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HI;
               d_nxt     = 1'b1;
               rise_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         IDLE_HI: begin
            d_nxt = 1'b1;
            if (!s_sync) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (s_sync) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LO;
               d_nxt     = 1'b0;
               fall_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
            d_nxt     = 1'b0;
         end
      endcase
      // busy tracks the registered state, so derive it from the next state.
      busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
   end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus randomized bouncing,
// compared every cycle against a sample-history model of the debouncer.
module tb_debounce_sync;

   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 16;
   // Edges from the edge that first captures a new btn_in level (edge 0) to the d_out change.
   localparam int LAT = SYNC_STAGES - 1 + STABLE_CYCLES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic d_out, rise_pulse, fall_pulse, busy;

   int errors = 0;
   int checks = 0;

   // Reference model: sync delay line as a queue of past samples, plus the
   // number of consecutive synced samples that disagree with the accepted level.
   bit sq[$];
   int m_run;
   bit m_d, m_rise, m_fall;

   debounce_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .d_out     (d_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_vec();
      return {m_d, m_rise, m_fall, (m_run > 0)};
   endfunction

   function automatic logic [3:0] dut_vec();
      return {d_out, rise_pulse, fall_pulse, busy};
   endfunction

   // Advance one clock edge, update the model with the inputs seen at that edge, sample #1 later.
   task automatic step();
      bit v;
      @(posedge clk);
      if (rst) begin
         sq.delete();
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sq.push_back(1'b0);
         m_run = 0; m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      end else begin
         v = sq[SYNC_STAGES-1];
         sq.push_front(btn_in);
         void'(sq.pop_back());
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (v != m_d) begin
            m_run++;
            if (m_run == STABLE_CYCLES) begin
               m_d    = v;
               m_rise = v;
               m_fall = !v;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      #1;
   endtask

   task automatic settle(input bit level, input int n);
      btn_in = level;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (dut_vec() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, dut_vec());
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if (dut_vec() !== 4'b0000 || model_vec() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i, dut_vec());
         end
      end
   endtask

   task automatic test_rise();
      int rise_edge = -1, nrise = 0, nbusy = 0;
      btn_in = 1'b1;
      for (int e = 0; e < 30; e++) begin
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL rise_cycle e=%0d got=%b exp=%b", e, dut_vec(), model_vec());
         end
         if (rise_pulse === 1'b1) begin nrise++; rise_edge = e; end
         if (busy === 1'b1) nbusy++;
      end
      checks++;
      if (rise_edge != LAT || nrise != 1) begin
         errors++;
         $display("FAIL rise_latency edge=%0d count=%0d exp edge=%0d count=1", rise_edge, nrise, LAT);
      end
      checks++;
      if (nbusy != STABLE_CYCLES - 1 || d_out !== 1'b1) begin
         errors++;
         $display("FAIL rise_busy busy_cycles=%0d d=%b exp %0d d=1", nbusy, d_out, STABLE_CYCLES - 1);
      end
   endtask

   task automatic test_glitch();
      int npulse = 0, nbusy = 0;
      settle(1'b0, 40);
      btn_in = 1'b1;
      for (int e = 0; e < 45; e++) begin
         if (e == STABLE_CYCLES - 1) btn_in = 1'b0;
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL glitch_cycle e=%0d got=%b exp=%b", e, dut_vec(), model_vec());
         end
         if (rise_pulse === 1'b1 || fall_pulse === 1'b1 || d_out !== 1'b0) npulse++;
         if (busy === 1'b1) nbusy++;
      end
      checks++;
      if (npulse != 0 || nbusy != STABLE_CYCLES - 1) begin
         errors++;
         $display("FAIL glitch_reject bad=%0d busy_cycles=%0d exp 0 and %0d", npulse, nbusy, STABLE_CYCLES - 1);
      end
   endtask

   task automatic test_bounce();
      bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int nrise = 0, rise_edge = -1, e = 0;
      settle(1'b0, 40);
      for (int p = 0; p < 4; p++) begin
         btn_in = pat[p];
         for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
               errors++;
               $display("FAIL bounce_cycle p=%0d got=%b exp=%b", p, dut_vec(), model_vec());
            end
            if (rise_pulse === 1'b1) nrise++;
         end
      end
      btn_in = 1'b1;
      for (e = 0; e < 30; e++) begin
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL bounce_hold e=%0d got=%b exp=%b", e, dut_vec(), model_vec());
         end
         if (rise_pulse === 1'b1) begin nrise++; rise_edge = e; end
      end
      checks++;
      if (nrise != 1 || rise_edge != LAT) begin
         errors++;
         $display("FAIL bounce_single count=%0d edge=%0d exp count=1 edge=%0d", nrise, rise_edge, LAT);
      end
   endtask

   task automatic test_fall();
      int fall_edge = -1, nfall = 0;
      settle(1'b1, 40);
      checks++;
      if (d_out !== 1'b1) begin
         errors++;
         $display("FAIL fall_pre d=%b exp=1", d_out);
      end
      btn_in = 1'b0;
      for (int e = 0; e < 30; e++) begin
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL fall_cycle e=%0d got=%b exp=%b", e, dut_vec(), model_vec());
         end
         if (fall_pulse === 1'b1) begin nfall++; fall_edge = e; end
      end
      checks++;
      if (nfall != 1 || fall_edge != LAT || d_out !== 1'b0) begin
         errors++;
         $display("FAIL fall_latency count=%0d edge=%0d d=%b exp 1, %0d, 0", nfall, fall_edge, d_out, LAT);
      end
   endtask

   task automatic test_rst_mid();
      int guard = 0, rise_edge = -1, nrise = 0;
      settle(1'b0, 40);
      btn_in = 1'b1;
      while (m_run != 8 && guard < 40) begin
         step();
         guard++;
      end
      checks++;
      if (busy !== 1'b1 || guard >= 40) begin
         errors++;
         $display("FAIL rstmid_reach busy=%b guard=%0d exp busy=1", busy, guard);
      end
      rst = 1'b1;
      step();
      checks++;
      if (dut_vec() !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_abort got=%b exp=0000", dut_vec());
      end
      rst = 1'b0;
      for (int e = 0; e < 30; e++) begin
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL rstmid_cycle e=%0d got=%b exp=%b", e, dut_vec(), model_vec());
         end
         if (rise_pulse === 1'b1) begin nrise++; rise_edge = e; end
      end
      checks++;
      if (nrise != 1 || rise_edge != LAT) begin
         errors++;
         $display("FAIL rstmid_requal count=%0d edge=%0d exp 1, %0d", nrise, rise_edge, LAT);
      end
   endtask

   task automatic test_random();
      int cyc = 0;
      while (cyc < 2000) begin
         int len = $urandom_range(1, STABLE_CYCLES + 8);
         btn_in = $urandom_range(0, 1);
         for (int k = 0; k < len; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            step();
            cyc++;
            checks++;
            if (dut_vec() !== model_vec()) begin
               errors++;
               $display("FAIL random_cycle c=%0d rst=%b got=%b exp=%b", cyc, rst, dut_vec(), model_vec());
            end
            checks++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
               errors++;
               $display("FAIL random_exclusive c=%0d rise=1 fall=1 exp not both", cyc);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_bounce();
      test_fall();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
